// File: rtl/two_bit_counter_pkg.sv
// Shared constants for the 2-bit mode-selectable counter: mode encodings
// and the active-low 7-segment digit patterns ({g,f,e,d,c,b,a}).
package two_bit_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_GRAY = 2'b11
    } mode_e;

    localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 2-bit value to active-low 7-segment digit (0-3).
import two_bit_counter_pkg::*;

module seg7_decoder (
    input  logic [1:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DIGIT_0;
        case (value_i)
            2'd0: seg_o = SEG_DIGIT_0;
            2'd1: seg_o = SEG_DIGIT_1;
            2'd2: seg_o = SEG_DIGIT_2;
            2'd3: seg_o = SEG_DIGIT_3;
            default: seg_o = SEG_DIGIT_0;
        endcase
    end

endmodule

// File: rtl/two_bit_counter.sv
// 2-bit counter with hold/up/down/Gray modes, enable, terminal-count flag,
// one-hot decode and 7-segment output; all outputs decode from count.
import two_bit_counter_pkg::*;

module two_bit_counter (
    input  logic       clock,
    input  logic       Reset,
    input  logic       En,
    input  logic [1:0] select,
    output logic [1:0] count,
    output logic [3:0] onehot,
    output logic       tc,
    output logic [6:0] seg
);

    logic [1:0] count_q, count_d;
    logic       wrap;
    mode_e      mode;

    assign mode = mode_e'(select);

    always_comb begin
        count_d = count_q;
        if (En) begin
            case (mode)
                MODE_UP:   count_d = count_q + 2'd1;
                MODE_DOWN: count_d = count_q - 2'd1;
                // Gray order 00->01->11->10 taken from whatever count holds now
                MODE_GRAY: begin
                    case (count_q)
                        2'b00:   count_d = 2'b01;
                        2'b01:   count_d = 2'b11;
                        2'b11:   count_d = 2'b10;
                        default: count_d = 2'b00;
                    endcase
                end
                default:   count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) count_q <= 2'b00;
        else        count_q <= count_d;
    end

    always_comb begin
        wrap = 1'b0;
        case (mode)
            MODE_UP:   wrap = (count_q == 2'b11);
            MODE_DOWN: wrap = (count_q == 2'b00);
            MODE_GRAY: wrap = (count_q == 2'b10);
            default:   wrap = 1'b0;
        endcase
    end

    assign tc     = En & wrap;
    assign count  = count_q;
    assign onehot = 4'b0001 << count_q;

    seg7_decoder u_seg (
        .value_i (count_q),
        .seg_o   (seg)
    );

endmodule

// File: tb/tb_two_bit_counter.sv
// Self-checking bench for two_bit_counter against an order-table reference model.
module tb_two_bit_counter;

    logic       clock = 1'b0;
    logic       Reset;
    logic       En;
    logic [1:0] select;
    logic [1:0] count;
    logic [3:0] onehot;
    logic       tc;
    logic [6:0] seg;

    int n_chk  = 0;
    int n_pass = 0;
    logic [1:0] m_cnt;
    logic [6:0] seg_tab [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};

    two_bit_counter dut (
        .clock  (clock),
        .Reset  (Reset),
        .En     (En),
        .select (select),
        .count  (count),
        .onehot (onehot),
        .tc     (tc),
        .seg    (seg)
    );

    always #5 clock = ~clock;

    // i-th value of the visiting order for a mode; index 3 is the terminal value
    function automatic logic [1:0] ord(input logic [1:0] sel, input int i);
        int v;
        case (sel)
            2'b01:   v = i;
            2'b10:   v = 3 - i;
            2'b11:   v = (i == 2) ? 3 : (i == 3) ? 2 : i;
            default: v = i;
        endcase
        return v[1:0];
    endfunction

    function automatic int pos(input logic [1:0] sel, input logic [1:0] c);
        for (int i = 0; i < 4; i++) if (ord(sel, i) == c) return i;
        return 0;
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] sel, input logic [1:0] c);
        if (sel == 2'b00) return c;
        return ord(sel, (pos(sel, c) + 1) % 4);
    endfunction

    function automatic logic tc_m(input logic e, input logic [1:0] sel, input logic [1:0] c);
        return e && sel != 2'b00 && pos(sel, c) == 3;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (Reset && En) m_cnt = nxt(select, m_cnt);
        @(negedge clock);
    endtask

    task automatic test_reset();
        Reset = 1'b0; En = 1'b1; select = 2'b10; m_cnt = 2'b00;
        for (int i = 0; i < 10; i++) begin
            #1;
            select = (i < 5) ? 2'b10 : ((i % 2) ? 2'b01 : 2'b11);
            #1;
            n_chk++;
            if (count !== 2'b00 || onehot !== 4'b0001 || seg !== 7'b1000000)
                $display("FAIL reset_outputs: count=%b onehot=%b seg=%b, want 00 0001 1000000", count, onehot, seg);
            else n_pass++;
            n_chk++;
            if (tc !== (select == 2'b10))
                $display("FAIL reset_tc: sel=%b tc=%b want %b", select, tc, select == 2'b10);
            else n_pass++;
            @(negedge clock);
        end
        Reset = 1'b1; En = 1'b0; select = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++;
            if (count !== 2'b00 || onehot !== 4'b0001 || tc !== 1'b0)
                $display("FAIL reset_hold: count=%b onehot=%b tc=%b want 00 0001 0", count, onehot, tc);
            else n_pass++;
        end
    endtask

    task automatic test_down();
        En = 1'b1; select = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_chk++;
            if (count !== m_cnt || tc !== (m_cnt == 2'b00))
                $display("FAIL down_seq: count=%b tc=%b want %b %b", count, tc, m_cnt, m_cnt == 2'b00);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_gray();
        En = 1'b1; select = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_chk++;
            if (count !== m_cnt || tc !== (m_cnt == 2'b10) || onehot !== (4'b0001 << m_cnt))
                $display("FAIL gray_seq: count=%b tc=%b onehot=%b want %b %b %b",
                         count, tc, onehot, m_cnt, m_cnt == 2'b10, 4'b0001 << m_cnt);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_up();
        En = 1'b1; select = 2'b01;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_chk++;
            if (count !== m_cnt || seg !== seg_tab[m_cnt] || tc !== (m_cnt == 2'b11))
                $display("FAIL up_seq: count=%b seg=%b tc=%b want %b %b %b",
                         count, seg, tc, m_cnt, seg_tab[m_cnt], m_cnt == 2'b11);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mid_controls();
        // bring count to 10 in up mode, then switch to down
        En = 1'b1; select = 2'b01;
        while (m_cnt != 2'b10) tick();
        select = 2'b10;
        tick();
        n_chk++;
        if (count !== 2'b01) $display("FAIL switch_up_down: count=%b want 01", count);
        else n_pass++;
        select = 2'b01;
        while (m_cnt != 2'b11) tick();
        En = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (count !== 2'b11 || tc !== 1'b0)
                $display("FAIL en_drop_hold: count=%b tc=%b want 11 0", count, tc);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        En = 1'b1; select = 2'b01;
        while (m_cnt != 2'b10) tick();
        #2 Reset = 1'b0; m_cnt = 2'b00;
        #1;
        n_chk++;
        if (count !== 2'b00) $display("FAIL async_reset: count=%b want 00 before edge", count);
        else n_pass++;
        @(posedge clock);
        #1;
        n_chk++;
        if (count !== 2'b00) $display("FAIL reset_held_edge: count=%b want 00", count);
        else n_pass++;
        @(negedge clock);
        Reset = 1'b1;
        tick();
        n_chk++;
        if (count !== 2'b01) $display("FAIL resume_after_reset: count=%b want 01", count);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            En = $urandom_range(0, 3) != 0;
            select = 2'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #2 Reset = 1'b0; m_cnt = 2'b00;
                #1 Reset = 1'b1;
            end
            #1;
            n_chk++;
            if (count !== m_cnt || onehot !== (4'b0001 << m_cnt) || seg !== seg_tab[m_cnt]
                || tc !== tc_m(En, select, m_cnt))
                $display("FAIL random[%0d]: en=%b sel=%b count=%b onehot=%b seg=%b tc=%b want %b %b %b %b",
                         i, En, select, count, onehot, seg, tc, m_cnt, 4'b0001 << m_cnt,
                         seg_tab[m_cnt], tc_m(En, select, m_cnt));
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_down();
        test_gray();
        test_up();
        test_mid_controls();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
